// File: rtl/expr_pipe_eval.sv
// expr_pipe_eval: two-stage valid/ready expression evaluator.
// Stage 1 captures the operands extended to 2W, the effective signedness and
// the op; stage 2 holds the evaluated 2W-bit result. Every accepted result
// updates a rotate-XOR signature and a transfer counter.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid, in_ready    operand handshake (in_ready is combinational)
//   a, b                  raw W-bit operands
//   a_signed, b_signed    per-operand signedness tags
//   op                    0 ADD,1 SUB,2 MUL,3 SHL,4 SHR,5 LT,6 EQ,7 RXOR
//   out_valid, out_ready  result handshake
//   y                     2W-bit result
//   clear_sig             synchronous clear of sig/count
//   sig, count            result signature and transfer count
module expr_pipe_eval #(
    parameter int unsigned W     = 6,
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      a,
    input  logic [W-1:0]      b,
    input  logic              a_signed,
    input  logic              b_signed,
    input  logic [2:0]        op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*W-1:0]    y,
    input  logic              clear_sig,
    output logic [2*W-1:0]    sig,
    output logic [CNT_W-1:0]  count
);

    localparam int unsigned YW = 2 * W;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_MUL  = 3'd2;
    localparam logic [2:0] OP_SHL  = 3'd3;
    localparam logic [2:0] OP_SHR  = 3'd4;
    localparam logic [2:0] OP_LT   = 3'd5;
    localparam logic [2:0] OP_EQ   = 3'd6;
    localparam logic [2:0] OP_RXOR = 3'd7;

    // Stage 1 state
    logic          s1_valid;
    logic [YW-1:0] s1_a;
    logic [YW-1:0] s1_b;
    logic          s1_s;
    logic [2:0]    s1_op;

    // Handshake control
    logic s2_load_c;
    logic s1_load_c;
    logic xfer_out_c;

    assign xfer_out_c = out_valid && out_ready;
    assign s2_load_c  = !out_valid || out_ready;
    assign s1_load_c  = !s1_valid || s2_load_c;
    assign in_ready   = s1_load_c;

    // Operand extension at the input
    logic          s_in_c;
    logic [YW-1:0] ea_c;
    logic [YW-1:0] eb_c;

    assign s_in_c = a_signed && b_signed;
    assign ea_c   = s_in_c ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    assign eb_c   = s_in_c ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};

    // Stage 1 register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_s     <= 1'b0;
            s1_op    <= '0;
        end else if (s1_load_c) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a  <= ea_c;
                s1_b  <= eb_c;
                s1_s  <= s_in_c;
                s1_op <= op;
            end
        end
    end

    // Evaluation of the stage 1 bundle; shift amount is the raw low W bits of b
    logic [YW-1:0] res_c;
    logic [W-1:0]  amt_c;
    logic          big_c;
    logic          lt_c;

    always_comb begin
        res_c = '0;
        amt_c = s1_b[W-1:0];
        big_c = (32'(amt_c) >= YW);
        lt_c  = s1_s ? ($signed(s1_a) < $signed(s1_b)) : (s1_a < s1_b);
        case (s1_op)
            OP_ADD:  res_c = s1_a + s1_b;
            OP_SUB:  res_c = s1_a - s1_b;
            OP_MUL:  res_c = s1_a * s1_b;
            OP_SHL:  res_c = big_c ? '0 : (s1_a << amt_c);
            OP_SHR: begin
                if (big_c) begin
                    res_c = (s1_s && s1_a[YW-1]) ? '1 : '0;
                end else if (s1_s) begin
                    res_c = YW'($signed(s1_a) >>> amt_c);
                end else begin
                    res_c = s1_a >> amt_c;
                end
            end
            OP_LT:   res_c = YW'(lt_c);
            OP_EQ:   res_c = YW'(s1_a == s1_b);
            OP_RXOR: res_c = YW'(^{s1_a[W-1:0], s1_b[W-1:0]});
            default: res_c = '0;
        endcase
    end

    // Stage 2 register (output)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            y         <= '0;
        end else if (s2_load_c) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                y <= res_c;
            end
        end
    end

    // Signature and transfer counter; clear wins but still folds in a same-cycle transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig   <= '0;
            count <= '0;
        end else if (clear_sig) begin
            sig   <= xfer_out_c ? y : '0;
            count <= xfer_out_c ? CNT_W'(1) : '0;
        end else if (xfer_out_c) begin
            sig   <= {sig[YW-2:0], sig[YW-1]} ^ y;
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_expr_pipe_eval.sv
// tb_expr_pipe_eval: directed self-checking bench for expr_pipe_eval (W=6, CNT_W=16).
module tb_expr_pipe_eval;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  a;
    logic [5:0]  b;
    logic        a_signed;
    logic        b_signed;
    logic [2:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] y;
    logic        clear_sig;
    logic [11:0] sig;
    logic [15:0] count;

    int n_checks;
    int n_errors;

    logic [11:0] exp_sig;
    logic [15:0] exp_cnt;

    expr_pipe_eval #(.W(6), .CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .a_signed  (a_signed),
        .b_signed  (b_signed),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .clear_sig (clear_sig),
        .sig       (sig),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference signature update for one transfer out
    task automatic model_xfer(input logic [11:0] yv, input logic clr);
        if (clr) begin
            exp_sig = yv;
            exp_cnt = 16'd1;
        end else begin
            exp_sig = {exp_sig[10:0], exp_sig[11]} ^ yv;
            exp_cnt = exp_cnt + 16'd1;
        end
    endtask

    // Called at posedge+1; leaves at posedge+1
    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        exp_sig = '0;
        exp_cnt = '0;
        @(posedge clk); #1;
    endtask

    // One isolated bundle with out_ready=1: accept, check latency and y, then transfer
    task automatic run_op(input string tag, input logic [2:0] o, input logic [5:0] av,
                          input logic [5:0] bv, input logic as_, input logic bs_,
                          input logic [11:0] ey, input logic clr);
        op = o; a = av; b = bv; a_signed = as_; b_signed = bs_;
        in_valid = 1'b1;
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({tag, "_early_valid"}, 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_y"}, 32'(y), 32'(ey));
        clear_sig = clr;
        @(posedge clk); #1;
        clear_sig = 1'b0;
        model_xfer(ey, clr);
        chk({tag, "_sig"}, 32'(sig), 32'(exp_sig));
        chk({tag, "_count"}, 32'(count), 32'(exp_cnt));
        chk({tag, "_drained"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        exp_sig = '0; exp_cnt = '0;
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0;
        a_signed = 1'b0; b_signed = 1'b0; op = '0;
        out_ready = 1'b1; clear_sig = 1'b0;

        // Reset state
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_y", 32'(y), 32'd0);
        chk("rst_sig", 32'(sig), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed operations
        run_op("add_s",    3'd0, 6'h3F, 6'h01, 1'b1, 1'b1, 12'h000, 1'b0);
        run_op("add_mix",  3'd0, 6'h3F, 6'h01, 1'b1, 1'b0, 12'h040, 1'b0);
        run_op("shr_s",    3'd4, 6'h20, 6'h02, 1'b1, 1'b1, 12'hFF8, 1'b0);
        run_op("shr_u",    3'd4, 6'h20, 6'h02, 1'b0, 1'b1, 12'h008, 1'b0);
        run_op("shr_big",  3'd4, 6'h20, 6'h0C, 1'b1, 1'b1, 12'hFFF, 1'b0);
        run_op("shr_bigu", 3'd4, 6'h20, 6'h0C, 1'b0, 1'b0, 12'h000, 1'b0);
        run_op("lt_s",     3'd5, 6'h3F, 6'h01, 1'b1, 1'b1, 12'h001, 1'b0);
        run_op("lt_mix",   3'd5, 6'h3F, 6'h01, 1'b0, 1'b1, 12'h000, 1'b0);
        run_op("lt_u",     3'd5, 6'h02, 6'h05, 1'b0, 1'b0, 12'h001, 1'b0);
        run_op("mul_s",    3'd2, 6'h3F, 6'h3F, 1'b1, 1'b1, 12'h001, 1'b0);
        run_op("mul_u",    3'd2, 6'h3F, 6'h3F, 1'b0, 1'b0, 12'hF81, 1'b0);
        run_op("sub_u",    3'd1, 6'h01, 6'h02, 1'b0, 1'b0, 12'hFFF, 1'b0);
        run_op("shl",      3'd3, 6'h01, 6'h05, 1'b0, 1'b0, 12'h020, 1'b0);
        run_op("shl_big",  3'd3, 6'h01, 6'h0C, 1'b0, 1'b0, 12'h000, 1'b0);
        run_op("eq",       3'd6, 6'h15, 6'h15, 1'b1, 1'b0, 12'h001, 1'b0);
        run_op("neq",      3'd6, 6'h15, 6'h14, 1'b1, 1'b1, 12'h000, 1'b0);
        run_op("rxor",     3'd7, 6'h03, 6'h01, 1'b0, 1'b0, 12'h001, 1'b0);

        // Backpressure: two bundles held, third refused, then all drain in order
        do_reset();
        out_ready = 1'b0;
        op = 3'd0; a_signed = 1'b0; b_signed = 1'b0;
        a = 6'h01; b = 6'h01; in_valid = 1'b1;
        chk("bp_rdy1", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        a = 6'h02; b = 6'h01;
        chk("bp_rdy2", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        a = 6'h03; b = 6'h01;
        chk("bp_full_rdy", 32'(in_ready), 32'd0);
        chk("bp_full_valid", 32'(out_valid), 32'd1);
        chk("bp_full_y", 32'(y), 32'h002);
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("bp_hold_y", 32'(y), 32'h002);
        chk("bp_hold_rdy", 32'(in_ready), 32'd0);
        chk("bp_hold_cnt", 32'(count), 32'd0);
        out_ready = 1'b1;
        #1;
        chk("bp_release_rdy", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_y2", 32'(y), 32'h003);
        @(posedge clk); #1;
        chk("bp_y3", 32'(y), 32'h004);
        chk("bp_y3_valid", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        model_xfer(12'h002, 1'b0);
        model_xfer(12'h003, 1'b0);
        model_xfer(12'h004, 1'b0);
        chk("bp_empty", 32'(out_valid), 32'd0);
        chk("bp_count", 32'(count), 32'd3);
        chk("bp_sig", 32'(sig), 32'(exp_sig));

        // Asynchronous reset with both stages full
        out_ready = 1'b0;
        a = 6'h07; b = 6'h01; in_valid = 1'b1;
        @(posedge clk); #1;
        a = 6'h08;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("ar_pre_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(out_valid), 32'd0);
        chk("ar_sig", 32'(sig), 32'd0);
        chk("ar_count", 32'(count), 32'd0);
        chk("ar_y", 32'(y), 32'd0);
        rst_n = 1'b1;
        exp_sig = '0; exp_cnt = '0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("ar_no_stale", 32'(out_valid), 32'd0);
        end
        chk("ar_rdy", 32'(in_ready), 32'd1);

        // Signature sequence and clear folded with a transfer
        run_op("sig1", 3'd0, 6'h00, 6'h01, 1'b0, 1'b0, 12'h001, 1'b0);
        chk("sig1_ref", 32'(sig), 32'h001);
        run_op("sig2", 3'd0, 6'h01, 6'h01, 1'b0, 1'b0, 12'h002, 1'b0);
        chk("sig2_ref", 32'(sig), 32'h000);
        chk("sig2_cnt", 32'(count), 32'd2);
        run_op("sig3", 3'd0, 6'h02, 6'h03, 1'b0, 1'b0, 12'h005, 1'b1);
        chk("sig3_ref", 32'(sig), 32'h005);
        chk("sig3_cnt", 32'(count), 32'd1);

        // Clear with no transfer
        clear_sig = 1'b1;
        @(posedge clk); #1;
        clear_sig = 1'b0;
        chk("clr_sig", 32'(sig), 32'd0);
        chk("clr_cnt", 32'(count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/expr_pipe_eval.md
EXPR_PIPE_EVAL -- requirements
Module: expr_pipe_eval

Interface
REQ-001 Parameter W, default 6, operand width in bits; legal range 2..16.
REQ-002 Parameter CNT_W, default 16, width of the transfer counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  operand bundle valid.
REQ-006 in_ready  output  1  block can accept a bundle this cycle.
REQ-007 a, b  input  W each  raw operand bits.
REQ-008 a_signed, b_signed  input  1 each  signedness tag per operand.
REQ-009 op  input  3  operation select (REQ-015).
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 y  output  2W  result.
REQ-013 clear_sig  input  1  synchronous clear of sig and count.
REQ-014 sig  output  2W; count  output  CNT_W  result signature and transfer count.

Function
REQ-015 op encoding: 0 ADD, 1 SUB, 2 MUL, 3 SHL, 4 SHR, 5 LT, 6 EQ, 7 RXOR.
REQ-016 Effective signedness S = a_signed AND b_signed; any mixed or unsigned pair evaluates fully unsigned.
REQ-017 Operands extend to 2W before evaluation: sign-extend when S=1, zero-extend otherwise.
REQ-018 ADD/SUB/MUL: result = low 2W bits of extended a op extended b.
REQ-019 SHL/SHR: shift amount = b as raw unsigned W bits; SHL logical; SHR arithmetic when S=1, logical otherwise; amount >= 2W gives 0, or all ones for SHR with S=1 and a negative.
REQ-020 LT: 1 when a < b under S, else 0; EQ: 1 when raw a == b; RXOR: XOR-reduce of {a,b}; all three zero-extended to 2W.
REQ-021 Two-stage pipeline: stage 1 registers extended operands, S and op; stage 2 registers y.
REQ-022 Latency: bundle accepted at edge N gives out_valid=1 with its y after edge N+1 when not stalled; throughput one per cycle.
REQ-023 Transfer in: in_valid AND in_ready at a rising edge; transfer out: out_valid AND out_ready.
REQ-024 Stage 2 loads when empty or transferring out; stage 1 loads when empty or advancing to stage 2; in_ready = stage 1 can load this cycle (combinational from out_ready allowed).
REQ-025 With out_ready held 0, block holds exactly two bundles, then in_ready=0; y and out_valid stable until transfer out.
REQ-026 Results emerge in acceptance order, none dropped or duplicated.
REQ-027 On each transfer out: sig <= rotate-left-by-1(sig) XOR y; count <= count+1, wrapping modulo 2^CNT_W.
REQ-028 clear_sig with no transfer out: sig <= 0, count <= 0; clear_sig with a transfer out the same cycle: sig <= y, count <= 1.
REQ-029 clear_sig does not affect pipeline contents or handshakes.

Reset
REQ-030 rst_n low asynchronously clears both stage valids, y, sig and count to 0; out_valid=0 immediately.
REQ-031 in_ready is 1 after reset release; in-flight bundles at reset are discarded, not emitted.
REQ-032 First active edge after rst_n rises behaves as normal operation.

Verification (W=6, CNT_W=16)
REQ-033 ADD a=6'h3F, b=6'h01, both signed -> y=12'h000; same with b_signed=0 -> y=12'h040.
REQ-034 SHR a=6'h20, b=2, both signed -> y=12'hFF8; a_signed=0 -> y=12'h008; b=6'h0C, signed -> y=12'hFFF.
REQ-035 LT a=6'h3F, b=6'h01 both signed -> y=1; mixed -> y=0; MUL a=b=6'h3F signed -> y=12'h001.
REQ-036 out_ready=0, three bundles offered back-to-back -> two accepted, in_ready=0; out_ready=1 -> all three emitted in order, count=3.
REQ-037 From reset, transfers y=12'h001 then 12'h002 -> sig=12'h001 then 12'h000, count=2; clear_sig with third transfer y=12'h005 -> sig=12'h005, count=1.
REQ-038 rst_n asserted with both stages full -> out_valid=0 without a clock edge, sig=0, count=0; no stale result after release.
